// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// datapath mux/ALU codes and the instruction classes produced by the decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } inst_class_e;

  // funct3[2] picks lt over eq, funct3[0] inverts the sense (BNE/BGE/BGEU).
  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq, input logic lt);
    return (funct3[2] ? lt : eq) ^ funct3[0];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IMEM word, compare flags, DMEM ready and all control strobes.
interface multicycle_ctrl_if;
  logic [31:0] inst_i;
  logic        BrEq_i;
  logic        BrLt_i;
  logic        mem_ready_i;
  logic [31:0] ir_o;
  logic        PCWE_o;
  logic        PCSel_o;
  logic        RegWEn_o;
  logic        Asel_o;
  logic        Bsel_o;
  logic        BrUn_o;
  logic        MemRW_o;
  logic [1:0]  WBSel_o;
  logic [2:0]  ImmSel_o;
  logic [3:0]  AluOp_o;

  modport master (
    input  inst_i, BrEq_i, BrLt_i, mem_ready_i,
    output ir_o, PCWE_o, PCSel_o, RegWEn_o, Asel_o, Bsel_o, BrUn_o, MemRW_o,
           WBSel_o, ImmSel_o, AluOp_o
  );

  modport slave (
    output inst_i, BrEq_i, BrLt_i, mem_ready_i,
    input  ir_o, PCWE_o, PCSel_o, RegWEn_o, Asel_o, Bsel_o, BrUn_o, MemRW_o,
           WBSel_o, ImmSel_o, AluOp_o
  );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction classifier: legality, class and the datapath mux/ALU selects.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output inst_class_e cls_o,
  output logic        Asel_o,
  output logic        Bsel_o,
  output logic [2:0]  ImmSel_o,
  output logic [3:0]  AluOp_o,
  output logic [1:0]  WBSel_o,
  output logic        BrUn_o
);

  logic f7Zero;
  logic f7Alt;

  assign f7Zero = (funct7_i == 7'b0000000);
  assign f7Alt  = (funct7_i == 7'b0100000);

  always_comb begin
    cls_o    = CLS_ILLEGAL;
    Asel_o   = 1'b0;
    Bsel_o   = 1'b0;
    ImmSel_o = IMM_I;
    AluOp_o  = ALU_ADD;
    WBSel_o  = WB_ALU;
    BrUn_o   = 1'b0;
    unique case (opcode_i)
      OPC_OP: begin
        unique case (funct3_i)
          3'b000: begin AluOp_o = f7Alt ? ALU_SUB : ALU_ADD; cls_o = (f7Zero || f7Alt) ? CLS_ALU : CLS_ILLEGAL; end
          3'b001: begin AluOp_o = ALU_SLL;  cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          3'b010: begin AluOp_o = ALU_SLT;  cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          3'b011: begin AluOp_o = ALU_SLTU; cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          3'b100: begin AluOp_o = ALU_XOR;  cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          3'b101: begin AluOp_o = f7Alt ? ALU_SRA : ALU_SRL; cls_o = (f7Zero || f7Alt) ? CLS_ALU : CLS_ILLEGAL; end
          3'b110: begin AluOp_o = ALU_OR;   cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          default: begin AluOp_o = ALU_AND; cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
        endcase
      end
      OPC_OPIMM: begin
        Bsel_o = 1'b1;
        cls_o  = CLS_ALU;
        unique case (funct3_i)
          3'b000: AluOp_o = ALU_ADD;
          3'b001: begin AluOp_o = ALU_SLL; cls_o = f7Zero ? CLS_ALU : CLS_ILLEGAL; end
          3'b010: AluOp_o = ALU_SLT;
          3'b011: AluOp_o = ALU_SLTU;
          3'b100: AluOp_o = ALU_XOR;
          3'b101: begin AluOp_o = f7Alt ? ALU_SRA : ALU_SRL; cls_o = (f7Zero || f7Alt) ? CLS_ALU : CLS_ILLEGAL; end
          3'b110: AluOp_o = ALU_OR;
          default: AluOp_o = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        Bsel_o  = 1'b1;
        WBSel_o = WB_MEM;
        cls_o   = (funct3_i == 3'b010) ? CLS_LOAD : CLS_ILLEGAL;
      end
      OPC_STORE: begin
        Bsel_o   = 1'b1;
        ImmSel_o = IMM_S;
        cls_o    = (funct3_i == 3'b010) ? CLS_STORE : CLS_ILLEGAL;
      end
      OPC_BRANCH: begin
        Asel_o   = 1'b1;
        Bsel_o   = 1'b1;
        ImmSel_o = IMM_B;
        BrUn_o   = funct3_i[1];
        cls_o    = (funct3_i[2:1] == 2'b01) ? CLS_ILLEGAL : CLS_BRANCH;
      end
      OPC_JAL: begin
        Asel_o   = 1'b1;
        Bsel_o   = 1'b1;
        ImmSel_o = IMM_J;
        WBSel_o  = WB_PC4;
        cls_o    = CLS_JUMP;
      end
      OPC_JALR: begin
        Bsel_o  = 1'b1;
        WBSel_o = WB_PC4;
        cls_o   = (funct3_i == 3'b000) ? CLS_JUMP : CLS_ILLEGAL;
      end
      OPC_LUI: begin
        Bsel_o   = 1'b1;
        ImmSel_o = IMM_U;
        AluOp_o  = ALU_PASSB;
        cls_o    = CLS_ALU;
      end
      OPC_AUIPC: begin
        Asel_o   = 1'b1;
        Bsel_o   = 1'b1;
        ImmSel_o = IMM_U;
        cls_o    = CLS_ALU;
      end
      OPC_SYSTEM: cls_o = CLS_SYSTEM;
      default:    cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: instruction register, FETCH..WB state machine,
// DMEM wait/timeout, retired-instruction counter and sticky halt/trap flags.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  multicycle_ctrl_if.master    dp,
  output logic [2:0]           state_o,
  output logic                 illegal_o,
  output logic                 mem_err_o,
  output logic                 halted_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [31:0]          ir_q, ir_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 memErr_q, memErr_d;
  logic                 halted_q, halted_d;
  logic                 pcwe, pcsel, regWe, memRw, retire;
  inst_class_e          cls;

  ctrl_decoder u_decoder (
    .opcode_i (ir_q[6:0]),
    .funct3_i (ir_q[14:12]),
    .funct7_i (ir_q[31:25]),
    .cls_o    (cls),
    .Asel_o   (dp.Asel_o),
    .Bsel_o   (dp.Bsel_o),
    .ImmSel_o (dp.ImmSel_o),
    .AluOp_o  (dp.AluOp_o),
    .WBSel_o  (dp.WBSel_o),
    .BrUn_o   (dp.BrUn_o)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    timer_d   = timer_q;
    illegal_d = illegal_q;
    memErr_d  = memErr_q;
    halted_d  = halted_q;
    pcwe      = 1'b0;
    pcsel     = 1'b0;
    regWe     = 1'b0;
    memRw     = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        ir_d    = dp.inst_i;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else if (cls == CLS_SYSTEM) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = ST_MEM;
          timer_d = '0;
        end else if (cls == CLS_BRANCH) begin
          pcwe    = 1'b1;
          pcsel   = branch_taken(ir_q[14:12], dp.BrEq_i, dp.BrLt_i);
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        memRw = (cls == CLS_STORE);
        // A ready arriving on the last allowed cycle still completes the access.
        if (dp.mem_ready_i) begin
          if (cls == CLS_STORE) begin
            pcwe    = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d  = ST_TRAP;
          memErr_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WB: begin
        regWe   = (ir_q[11:7] != 5'd0);
        pcwe    = 1'b1;
        pcsel   = (cls == CLS_JUMP);
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT, ST_TRAP: state_d = state_q;
      default:          state_d = ST_FETCH;
    endcase
  end

  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      timer_q   <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      memErr_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      timer_q   <= timer_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      memErr_q  <= memErr_d;
      halted_q  <= halted_d;
    end
  end

  // Write-type strobes drop the moment reset asserts, before the next edge.
  assign dp.PCWE_o   = pcwe & rst_ni;
  assign dp.RegWEn_o = regWe & rst_ni;
  assign dp.MemRW_o  = memRw & rst_ni;
  assign dp.PCSel_o  = pcsel;
  assign dp.ir_o     = ir_q;
  assign state_o     = state_q;
  assign illegal_o   = illegal_q;
  assign mem_err_o   = memErr_q;
  assign halted_o    = halted_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: one linear sequence of instructions,
// checked on the falling edge against hand-computed values.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rstN;
  logic [2:0]  stateO;
  logic        illegalO;
  logic        memErrO;
  logic        haltedO;
  logic [31:0] instretO;
  int          compared;
  int          mismatched;

  multicycle_ctrl_if dpIf ();

  multicycle_ctrl #(.INSTRET_W(32), .MEM_TIMEOUT(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .dp        (dpIf),
    .state_o   (stateO),
    .illegal_o (illegalO),
    .mem_err_o (memErrO),
    .halted_o  (haltedO),
    .instret_o (instretO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [31:0] inst, input logic brEq, input logic brLt,
                               input logic ready);
    dpIf.inst_i      = inst;
    dpIf.BrEq_i      = brEq;
    dpIf.BrLt_i      = brLt;
    dpIf.mem_ready_i = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rstN       = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    checkOutput("reset_state", 32'(stateO), 32'd0);
    checkOutput("reset_ir", dpIf.ir_o, 32'd0);
    checkOutput("reset_instret", instretO, 32'd0);
    checkOutput("reset_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    rstN = 1'b1;

    // add x3,x1,x2
    applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
    checkOutput("add_fetch", 32'(stateO), 32'd0);
    step();
    checkOutput("add_decode", 32'(stateO), 32'd1);
    checkOutput("add_ir", dpIf.ir_o, 32'h002081B3);
    step();
    checkOutput("add_exec", 32'(stateO), 32'd2);
    checkOutput("add_exec_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    step();
    checkOutput("add_wb", 32'(stateO), 32'd4);
    checkOutput("add_wb_regwen", 32'(dpIf.RegWEn_o), 32'd1);
    checkOutput("add_wb_pcwe", 32'(dpIf.PCWE_o), 32'd1);
    checkOutput("add_wb_pcsel", 32'(dpIf.PCSel_o), 32'd0);
    checkOutput("add_wb_aluop", 32'(dpIf.AluOp_o), 32'd0);
    checkOutput("add_wb_wbsel", 32'(dpIf.WBSel_o), 32'd1);
    checkOutput("add_wb_instret", instretO, 32'd0);
    step();
    checkOutput("add_retired", instretO, 32'd1);
    checkOutput("add_back_fetch", 32'(stateO), 32'd0);

    // jal x1,+8
    applyStimulus(32'h008000EF, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("jal_asel", 32'(dpIf.Asel_o), 32'd1);
    checkOutput("jal_immsel", 32'(dpIf.ImmSel_o), 32'd3);
    step();
    checkOutput("jal_wb_pcsel", 32'(dpIf.PCSel_o), 32'd1);
    checkOutput("jal_wb_wbsel", 32'(dpIf.WBSel_o), 32'd2);
    checkOutput("jal_wb_regwen", 32'(dpIf.RegWEn_o), 32'd1);
    step();
    checkOutput("jal_retired", instretO, 32'd2);

    // beq x1,x2,+8 taken, then not taken
    applyStimulus(32'h00208463, 1'b1, 1'b0, 1'b0);
    step();
    step();
    checkOutput("beq_t_exec", 32'(stateO), 32'd2);
    checkOutput("beq_t_pcwe", 32'(dpIf.PCWE_o), 32'd1);
    checkOutput("beq_t_pcsel", 32'(dpIf.PCSel_o), 32'd1);
    checkOutput("beq_t_immsel", 32'(dpIf.ImmSel_o), 32'd2);
    checkOutput("beq_t_regwen", 32'(dpIf.RegWEn_o), 32'd0);
    checkOutput("beq_t_asel", 32'(dpIf.Asel_o), 32'd1);
    step();
    checkOutput("beq_t_fetch", 32'(stateO), 32'd0);
    checkOutput("beq_t_retired", instretO, 32'd3);
    applyStimulus(32'h00208463, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("beq_nt_pcwe", 32'(dpIf.PCWE_o), 32'd1);
    checkOutput("beq_nt_pcsel", 32'(dpIf.PCSel_o), 32'd0);
    step();
    checkOutput("beq_nt_retired", instretO, 32'd4);

    // lw x3,0(x1): ready low for three MEM cycles, high on the fourth
    applyStimulus(32'h0000A183, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("lw_exec_bsel", 32'(dpIf.Bsel_o), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("lw_mem_wait", 32'(stateO), 32'd3);
      checkOutput("lw_mem_memrw", 32'(dpIf.MemRW_o), 32'd0);
      step();
    end
    dpIf.mem_ready_i = 1'b1;
    checkOutput("lw_mem_ready", 32'(stateO), 32'd3);
    checkOutput("lw_mem_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    step();
    dpIf.mem_ready_i = 1'b0;
    checkOutput("lw_wb", 32'(stateO), 32'd4);
    checkOutput("lw_wb_wbsel", 32'(dpIf.WBSel_o), 32'd0);
    checkOutput("lw_wb_regwen", 32'(dpIf.RegWEn_o), 32'd1);
    checkOutput("lw_wb_pcwe", 32'(dpIf.PCWE_o), 32'd1);
    step();
    checkOutput("lw_retired", instretO, 32'd5);

    // addi x0,x0,0: rd==0 suppresses the register write but still advances PC
    applyStimulus(32'h00000013, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    checkOutput("nop_wb_regwen", 32'(dpIf.RegWEn_o), 32'd0);
    checkOutput("nop_wb_pcwe", 32'(dpIf.PCWE_o), 32'd1);
    step();
    checkOutput("nop_retired", instretO, 32'd6);

    // sw with ready never arriving: 16 MEM cycles then TRAP
    applyStimulus(32'h0020A023, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("sw_exec_immsel", 32'(dpIf.ImmSel_o), 32'd1);
    step();
    for (int i = 0; i < 16; i++) begin
      checkOutput("sw_mem_state", 32'(stateO), 32'd3);
      checkOutput("sw_mem_pcwe", 32'(dpIf.PCWE_o), 32'd0);
      checkOutput("sw_mem_memrw", 32'(dpIf.MemRW_o), 32'd1);
      step();
    end
    checkOutput("sw_trap_state", 32'(stateO), 32'd6);
    checkOutput("sw_trap_memerr", 32'(memErrO), 32'd1);
    checkOutput("sw_trap_instret", instretO, 32'd6);
    step();
    checkOutput("sw_trap_stay", 32'(stateO), 32'd6);
    checkOutput("sw_trap_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    checkOutput("sw_trap_memrw", 32'(dpIf.MemRW_o), 32'd0);

    // illegal word after reset
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    checkOutput("rst_clears_memerr", 32'(memErrO), 32'd0);
    checkOutput("rst_clears_instret", instretO, 32'd0);
    applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("ill_trap", 32'(stateO), 32'd6);
    checkOutput("ill_flag", 32'(illegalO), 32'd1);
    step();
    checkOutput("ill_stay", 32'(stateO), 32'd6);
    checkOutput("ill_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    checkOutput("ill_regwen", 32'(dpIf.RegWEn_o), 32'd0);
    checkOutput("ill_memrw", 32'(dpIf.MemRW_o), 32'd0);

    // ecall halts
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    checkOutput("rst_clears_illegal", 32'(illegalO), 32'd0);
    applyStimulus(32'h00000073, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("ecall_halt", 32'(stateO), 32'd5);
    checkOutput("ecall_flag", 32'(haltedO), 32'd1);
    step();
    checkOutput("ecall_stay", 32'(stateO), 32'd5);
    checkOutput("ecall_pcwe", 32'(dpIf.PCWE_o), 32'd0);
    checkOutput("ecall_instret", instretO, 32'd0);

    // reset asserted in the middle of a store's MEM phase
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    applyStimulus(32'h0020A023, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    checkOutput("swrst_mem", 32'(stateO), 32'd3);
    checkOutput("swrst_memrw_before", 32'(dpIf.MemRW_o), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("swrst_memrw_comb", 32'(dpIf.MemRW_o), 32'd0);
    checkOutput("swrst_pcwe_comb", 32'(dpIf.PCWE_o), 32'd0);
    step();
    rstN = 1'b1;
    checkOutput("swrst_state", 32'(stateO), 32'd0);
    checkOutput("swrst_instret", instretO, 32'd0);
    checkOutput("swrst_halted", 32'(haltedO), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
